// File: rtl/memoria_pkg.sv
// rtl/memoria_pkg.sv - shared constants for the parametrised data memory
// State encoding and default widths used by the top level and its bus interface.
package memoria_pkg;

  localparam logic [0:0] ST_LIMPA  = 1'b0;
  localparam logic [0:0] ST_PRONTO = 1'b1;

  localparam int DATA_W_PADRAO = 8;
  localparam int ADDR_W_PADRAO = 8;

endpackage

// File: rtl/memoria_dados_parametrizada_if.sv
// rtl/memoria_dados_parametrizada_if.sv - datapath-side bus of the data memory
// The master is the datapath issuing requests; the slave is the memory.
interface memoria_dados_parametrizada_if
  import memoria_pkg::*;
#(
  parameter int DATA_W = DATA_W_PADRAO,
  parameter int ADDR_W = ADDR_W_PADRAO
);

  logic [ADDR_W-1:0] Endereco;
  logic [DATA_W-1:0] DadoEscr;
  logic              MenWrite;
  logic              MenRead;
  logic [DATA_W-1:0] DadoLido;
  logic              LeituraValida;
  logic              ErroEndereco;
  logic              Pronto;

  modport master (
    output Endereco, DadoEscr, MenWrite, MenRead,
    input  DadoLido, LeituraValida, ErroEndereco, Pronto
  );

  modport slave (
    input  Endereco, DadoEscr, MenWrite, MenRead,
    output DadoLido, LeituraValida, ErroEndereco, Pronto
  );

endinterface

// File: rtl/memoria_dados_banco.sv
// rtl/memoria_dados_banco.sv - DEPTH x DATA_W storage array
// Synchronous write, combinational read, no reset: contents are set by the clear sequence.
module memoria_dados_banco #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memoria_dados_parametrizada.sv
// rtl/memoria_dados_parametrizada.sv - parametrised data memory with post-reset clear
// Holds the clear FSM, address range check, write-first bypass and registered read outputs.
module memoria_dados_parametrizada
  import memoria_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_PADRAO,
  parameter int                ADDR_W     = ADDR_W_PADRAO,
  parameter int                DEPTH      = 256,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input logic                    Clock,
  input logic                    Reset,
  memoria_dados_parametrizada_if.slave bus
);

  // One extra bit so DEPTH == 2**ADDR_W is representable and never flags an error.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ULTIMO  = ADDR_W'(DEPTH - 1);

  logic [0:0]        estado;
  logic [ADDR_W-1:0] contador;
  logic [DATA_W-1:0] dado_lido;
  logic              leitura_valida;
  logic              erro_endereco;

  logic              em_faixa;
  logic              banco_we;
  logic [ADDR_W-1:0] banco_waddr;
  logic [DATA_W-1:0] banco_wdata;
  logic [DATA_W-1:0] banco_rdata;

  assign em_faixa = ({1'b0, bus.Endereco} < DEPTH_L);

  always_comb begin
    banco_we    = 1'b0;
    banco_waddr = bus.Endereco;
    banco_wdata = bus.DadoEscr;
    if (estado == ST_LIMPA) begin
      banco_we    = 1'b1;
      banco_waddr = contador;
      banco_wdata = INIT_VALUE;
    end else if (bus.MenWrite && em_faixa) begin
      banco_we = 1'b1;
    end
  end

  memoria_dados_banco #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_banco (
    .clk   (Clock),
    .we    (banco_we),
    .waddr (banco_waddr),
    .wdata (banco_wdata),
    .raddr (bus.Endereco),
    .rdata (banco_rdata)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado         <= ST_LIMPA;
      contador       <= '0;
      dado_lido      <= '0;
      leitura_valida <= 1'b0;
      erro_endereco  <= 1'b0;
    end else begin
      case (estado)
        ST_LIMPA: begin
          leitura_valida <= 1'b0;
          erro_endereco  <= 1'b0;
          if (contador == ULTIMO) begin
            estado <= ST_PRONTO;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        default: begin
          leitura_valida <= bus.MenRead;
          erro_endereco  <= (bus.MenRead || bus.MenWrite) && !em_faixa;
          if (bus.MenRead) begin
            // Write-first: a simultaneous write is returned instead of the stale word.
            if (!em_faixa) begin
              dado_lido <= '0;
            end else if (bus.MenWrite) begin
              dado_lido <= bus.DadoEscr;
            end else begin
              dado_lido <= banco_rdata;
            end
          end
        end
      endcase
    end
  end

  assign bus.DadoLido      = dado_lido;
  assign bus.LeituraValida = leitura_valida;
  assign bus.ErroEndereco  = erro_endereco;
  assign bus.Pronto        = (estado == ST_PRONTO);

endmodule

// File: tb/tb_memoria_dados_parametrizada.sv
// tb/tb_memoria_dados_parametrizada.sv - directed self-checking bench for the data memory
// Instance a: DEPTH=200, INIT 8'hA5. Instance b: DEPTH=256, INIT 8'h00.
module tb_memoria_dados_parametrizada;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   n;

  memoria_dados_parametrizada_if #(.DATA_W(8), .ADDR_W(8)) bus_a ();
  memoria_dados_parametrizada_if #(.DATA_W(8), .ADDR_W(8)) bus_b ();

  memoria_dados_parametrizada #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(200), .INIT_VALUE(8'hA5)
  ) dut_a (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus_a.slave)
  );

  memoria_dados_parametrizada #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(256), .INIT_VALUE(8'h00)
  ) dut_b (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_a();
    bus_a.MenWrite = 1'b0;
    bus_a.MenRead  = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus_a.Endereco = '0; bus_a.DadoEscr = '0; bus_a.MenWrite = 1'b0; bus_a.MenRead = 1'b0;
    bus_b.Endereco = '0; bus_b.DadoEscr = '0; bus_b.MenWrite = 1'b0; bus_b.MenRead = 1'b0;

    // Reset state
    #1;
    chk("rst_pronto", 32'(bus_a.Pronto), 0);
    chk("rst_dado", 32'(bus_a.DadoLido), 0);
    chk("rst_valida", 32'(bus_a.LeituraValida), 0);
    chk("rst_erro", 32'(bus_a.ErroEndereco), 0);
    tick();
    tick();
    rst = 1'b0;

    // 1: clear takes exactly 200 edges, then every word reads 8'hA5
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (bus_a.Pronto) break;
    end
    chk("clear_cycles", 32'(n), 200);
    chk("clear_no_valida", 32'(bus_a.LeituraValida), 0);
    for (int i = 0; i < 200; i++) begin
      bus_a.Endereco = 8'(i);
      bus_a.MenRead  = 1'b1;
      tick();
      chk("init_read", 32'(bus_a.DadoLido), 32'h A5);
      chk("init_valida", 32'(bus_a.LeituraValida), 1);
    end
    idle_a();

    // 2: write i at i, then back-to-back reads
    for (int i = 0; i < 200; i++) begin
      bus_a.Endereco = 8'(i);
      bus_a.DadoEscr = 8'(i);
      bus_a.MenWrite = 1'b1;
      tick();
      chk("wr_no_valida", 32'(bus_a.LeituraValida), 0);
    end
    idle_a();
    for (int i = 0; i < 200; i++) begin
      bus_a.Endereco = 8'(i);
      bus_a.MenRead  = 1'b1;
      tick();
      chk("b2b_read", 32'(bus_a.DadoLido), 32'(i));
      chk("b2b_valida", 32'(bus_a.LeituraValida), 1);
    end
    idle_a();
    tick();
    chk("hold_valida", 32'(bus_a.LeituraValida), 0);
    chk("hold_dado", 32'(bus_a.DadoLido), 199);

    // 3: simultaneous write and read -> bypass
    bus_a.Endereco = 8'd10;
    bus_a.DadoEscr = 8'h3C;
    bus_a.MenWrite = 1'b1;
    bus_a.MenRead  = 1'b1;
    tick();
    chk("bypass_dado", 32'(bus_a.DadoLido), 32'h3C);
    chk("bypass_valida", 32'(bus_a.LeituraValida), 1);
    idle_a();
    tick();
    bus_a.MenRead = 1'b1;
    tick();
    chk("bypass_reread", 32'(bus_a.DadoLido), 32'h3C);
    idle_a();

    // 4: out-of-range write and read
    bus_a.Endereco = 8'd220;
    bus_a.DadoEscr = 8'hFF;
    bus_a.MenWrite = 1'b1;
    tick();
    chk("oor_wr_erro", 32'(bus_a.ErroEndereco), 1);
    chk("oor_wr_valida", 32'(bus_a.LeituraValida), 0);
    idle_a();
    tick();
    chk("oor_erro_pulse", 32'(bus_a.ErroEndereco), 0);
    bus_a.MenRead = 1'b1;
    tick();
    chk("oor_rd_dado", 32'(bus_a.DadoLido), 0);
    chk("oor_rd_valida", 32'(bus_a.LeituraValida), 1);
    chk("oor_rd_erro", 32'(bus_a.ErroEndereco), 1);
    bus_a.Endereco = 8'd199;
    tick();
    chk("oor_199_dado", 32'(bus_a.DadoLido), 199);
    chk("oor_199_erro", 32'(bus_a.ErroEndereco), 0);
    idle_a();

    // 6: full-depth instance never errors and stores address 255
    chk("b_pronto", 32'(bus_b.Pronto), 1);
    bus_b.Endereco = 8'd255;
    bus_b.DadoEscr = 8'h5A;
    bus_b.MenWrite = 1'b1;
    tick();
    chk("b_wr_erro", 32'(bus_b.ErroEndereco), 0);
    bus_b.MenWrite = 1'b0;
    bus_b.MenRead  = 1'b1;
    tick();
    chk("b_rd_dado", 32'(bus_b.DadoLido), 32'h5A);
    chk("b_rd_valida", 32'(bus_b.LeituraValida), 1);
    chk("b_rd_erro", 32'(bus_b.ErroEndereco), 0);
    bus_b.MenRead = 1'b0;

    // 5: reset mid-clear restarts a full clear; writes during clear are ignored
    rst = 1'b1;
    #1;
    chk("async_pronto", 32'(bus_a.Pronto), 0);
    chk("async_dado", 32'(bus_a.DadoLido), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("mid_pronto", 32'(bus_a.Pronto), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_pronto", 32'(bus_a.Pronto), 0);
    tick();
    rst = 1'b0;
    bus_a.Endereco = 8'd5;
    bus_a.DadoEscr = 8'h11;
    bus_a.MenWrite = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (n == 3) bus_a.MenWrite = 1'b0;
      chk("clear2_valida", 32'(bus_a.LeituraValida), 0);
      if (bus_a.Pronto) break;
    end
    chk("clear2_cycles", 32'(n), 200);
    bus_a.MenRead = 1'b1;
    tick();
    chk("clear2_rd5", 32'(bus_a.DadoLido), 32'hA5);
    bus_a.Endereco = 8'd10;
    tick();
    chk("clear2_rd10", 32'(bus_a.DadoLido), 32'hA5);
    idle_a();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
